rvh_l1d_mshr_alloc_arb: RTL and testbench
=========================================

Name: rvh_l1d_mshr_alloc_arb

Overview:
Arbitrates MSHR allocation requests from N_REQ L1D miss sources (load pipes, store-buffer evict path) and hands one free MSHR id per cycle to the MSHR bank. Keeps its own busy vector of allocated entries and selects the lowest free id. Detects line-address conflicts against in-flight MSHRs so requesters replay instead of double-allocating. Sits between the L1D miss pipes and the MSHR bank (drives new_mshr_valid_i/new_mshr_id_i) and consumes the MLFB dealloc stream.

Parameters:
N_REQ, 2, number of allocation requesters
N_MSHR, 4, number of MSHR entries
N_MSHR_W, 2, log2(N_MSHR)
LINE_ADDR_W, 14, line address width: tag (12) + set index (2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid_i  in  N_REQ  per-requester allocation request
req_line_addr_i  in  N_REQ*LINE_ADDR_W  per-requester miss line address
req_ready_o  out  N_REQ  grant this cycle; the request is consumed
req_conflict_o  out  N_REQ  line already owned by a busy MSHR; requester must replay
alloc_valid_o  out  1  registered allocation strobe to the MSHR bank
alloc_id_o  out  N_MSHR_W  registered allocated id
alloc_req_idx_o  out  $clog2(N_REQ)  registered index of the winning requester
alloc_line_addr_o  out  LINE_ADDR_W  registered line address of the winner
dealloc_valid_i  in  1  MLFB frees an entry
dealloc_idx_i  in  N_MSHR_W  entry being freed
rob_flush_i  in  1  pipeline flush; suppresses grants in this cycle
full_o  out  1  all entries busy
free_cnt_o  out  N_MSHR_W+1  number of non-busy entries

Behaviour:
- Reset (synchronous, rst=1): busy_q=0, line_q[*]=0, rr_ptr_q=0, alloc_valid_o=0, alloc_id_o=0, alloc_req_idx_o=0, alloc_line_addr_o=0. Combinational outputs follow: full_o=0, free_cnt_o=N_MSHR, req_ready_o=0, req_conflict_o=0.
- State: busy_q[N_MSHR], line_q[N_MSHR] (line address stored at grant), rr_ptr_q.
- Conflict (combinational): req_conflict_o[r] = req_valid_i[r] & OR over e of (busy_q[e] & line_q[e]==req_line_addr_i[r]). Entries freed in the current cycle still count as busy. Conflicting requesters are never granted.
- Eligible[r] = req_valid_i[r] & ~req_conflict_o[r].
- Grant: if ~rob_flush_i, ~full_o and any requester is eligible, pick the first eligible requester starting at rr_ptr_q, wrapping around. req_ready_o is one-hot on the winner, 0 otherwise. Losers see ready=0 and conflict=0, and must hold their request.
- Same-line, same-cycle requests from two requesters: only the RR winner is granted. Next cycle the loser sees a conflict.
- Free id: the lowest e with busy_q[e]=0. An entry freed this cycle is not reusable until the next cycle.
- Grant cycle updates (visible next cycle): busy_q[id] set; line_q[id] loaded; rr_ptr_q = winner+1 mod N_REQ; alloc_valid_o=1; alloc_id_o, alloc_req_idx_o and alloc_line_addr_o loaded.
- Latency: one cycle from req_ready_o to alloc_valid_o. alloc_valid_o is a single-cycle pulse and drops to 0 when there is no grant. rr_ptr_q holds when there is no grant.
- Dealloc: dealloc_valid_i clears busy_q[dealloc_idx_i] at the clock edge. A dealloc and an alloc of different ids in the same cycle both take effect. A dealloc of the id being allocated cannot occur, because freed ids are excluded. A dealloc of a non-busy entry has no effect; the bench flags it as a protocol error.
- rob_flush_i blocks grants only in the flush cycle. busy_q and in-flight entries are untouched, since the MSHR bank tracks no_resp itself.
- full_o = &busy_q. free_cnt_o = popcount(~busy_q). Both are combinational from state only.
- Reset asserted mid-operation: all state returns to reset values on the next edge, and pending allocations are dropped.

Decomposition:
- Shared package rvh_l1d_pkg holds N_MSHR, N_MSHR_W, L1D_BANK_PADDR_TAG_WIDTH and L1D_BANK_SET_INDEX_WIDTH. LINE_ADDR_W is derived from the last two.
- One natural sub-module: rvh_l1d_rr_arb (N_REQ-wide round-robin arbiter: request vector plus pointer in, one-hot grant out).
- The lowest-free-id finder and the popcount stay inline.

Test Plan:
- Reset, then req_valid_i=01 with addr 0x0A5 -> req_ready_o=01 that cycle; next cycle alloc_valid_o=1, alloc_id_o=0, alloc_req_idx_o=0, free_cnt_o=3.
- Both requesters valid with distinct addrs for 4 consecutive cycles -> grants alternate r0,r1,r0,r1, ids 0,1,2,3; full_o=1 after the 4th; a 5th request gets ready=0 and no alloc_valid_o.
- Entry 2 holds line 0x123, then r1 requests 0x123 -> req_conflict_o[1]=1, req_ready_o[1]=0, busy unchanged; after dealloc of idx 2, the retry is granted id 2.
- Full, then dealloc_idx_i=1 with a request in the same cycle -> no grant that cycle; next cycle granted id 1.
- Both requesters request the same line 0x0FF in one cycle -> only the RR winner is granted; next cycle the loser sees conflict=1.
- rob_flush_i=1 with a valid request -> req_ready_o=0, alloc_valid_o=0 next cycle, busy_q unchanged; with flush low the request is granted.

Source files
------------

// File: rtl/rvh_l1d_pkg.sv
// -----------------------------------------------------------------------------
// rvh_l1d_pkg
// Shared L1D constants: MSHR sizing and the line-address layout
// (tag + set index) used by the MSHR allocation arbiter.
// -----------------------------------------------------------------------------
package rvh_l1d_pkg;

    localparam int N_MSHR                   = 4;
    localparam int N_MSHR_W                 = 2;
    localparam int L1D_BANK_PADDR_TAG_WIDTH = 12;
    localparam int L1D_BANK_SET_INDEX_WIDTH = 2;

    // A line address is the tag concatenated with the set index.
    localparam int LINE_ADDR_W = L1D_BANK_PADDR_TAG_WIDTH + L1D_BANK_SET_INDEX_WIDTH;

    typedef logic [LINE_ADDR_W-1:0] line_addr_t;

endpackage

// File: rtl/rvh_l1d_rr_arb.sv
// -----------------------------------------------------------------------------
// rvh_l1d_rr_arb
// N-wide round-robin arbiter. Scans the request vector starting at the
// pointer position, wrapping around, and grants the first asserted request.
//
// Ports:
//   req    in   N       request vector
//   ptr    in   PTR_W   highest-priority position for this cycle
//   grant  out  N       one-hot grant (all zero when no request)
// -----------------------------------------------------------------------------
module rvh_l1d_rr_arb #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic [PTR_W-1:0] idx_s;
    logic             found_s;

    // Rotating priority scan: first request at or after ptr wins.
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int i = 0; i < N; i++) begin
            idx_s = PTR_W'((int'(ptr) + i) % N);
            if (!found_s && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/rvh_l1d_mshr_alloc_arb.sv
// -----------------------------------------------------------------------------
// rvh_l1d_mshr_alloc_arb
// Arbitrates MSHR allocation requests from N_REQ L1D miss sources and hands
// out at most one free MSHR id per cycle (lowest free id). Tracks which
// entries are busy and which line each owns, so a requester whose line is
// already in flight is told to replay instead of double-allocating.
//
// Ports:
//   clk, rst                synchronous active-high reset
//   req_valid_i             per-requester allocation request
//   req_line_addr_i         per-requester line address (packed, r0 in LSBs)
//   req_ready_o             one-hot grant this cycle (combinational)
//   req_conflict_o          line owned by a busy MSHR, replay (combinational)
//   alloc_valid_o           registered single-cycle allocation strobe
//   alloc_id_o              registered allocated MSHR id
//   alloc_req_idx_o         registered winning requester index
//   alloc_line_addr_o       registered winning line address
//   dealloc_valid_i/idx_i   entry freed by the MLFB
//   rob_flush_i             suppresses grants in this cycle only
//   full_o, free_cnt_o      occupancy, combinational from state
// -----------------------------------------------------------------------------
module rvh_l1d_mshr_alloc_arb
    import rvh_l1d_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int REQ_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid_i,
    input  logic [N_REQ*LINE_ADDR_W-1:0] req_line_addr_i,
    output logic [N_REQ-1:0]             req_ready_o,
    output logic [N_REQ-1:0]             req_conflict_o,
    output logic                         alloc_valid_o,
    output logic [N_MSHR_W-1:0]          alloc_id_o,
    output logic [REQ_W-1:0]             alloc_req_idx_o,
    output logic [LINE_ADDR_W-1:0]       alloc_line_addr_o,
    input  logic                         dealloc_valid_i,
    input  logic [N_MSHR_W-1:0]          dealloc_idx_i,
    input  logic                         rob_flush_i,
    output logic                         full_o,
    output logic [N_MSHR_W:0]            free_cnt_o
);

    // State
    logic [N_MSHR-1:0]    busy_r;
    line_addr_t           line_r [N_MSHR];
    logic [REQ_W-1:0]     rr_ptr_r;
    logic                 alloc_valid_r;
    logic [N_MSHR_W-1:0]  alloc_id_r;
    logic [REQ_W-1:0]     alloc_req_idx_r;
    line_addr_t           alloc_line_addr_r;

    // Combinational
    line_addr_t           req_addr_s [N_REQ];
    logic [N_REQ-1:0]     conflict_s;
    logic [N_REQ-1:0]     eligible_s;
    logic [N_REQ-1:0]     arb_grant_s;
    logic [N_REQ-1:0]     grant_s;
    logic                 grant_en_s;
    logic                 full_s;
    logic [N_MSHR_W:0]    free_cnt_s;
    logic [N_MSHR_W-1:0]  free_id_s;
    logic [REQ_W-1:0]     win_idx_s;
    line_addr_t           win_addr_s;
    logic [REQ_W-1:0]     rr_next_s;
    logic [N_MSHR-1:0]    dealloc_mask_s;
    logic [N_MSHR-1:0]    alloc_mask_s;

    // Unpack the flat request address bus into per-requester lanes.
    always_comb begin
        for (int r = 0; r < N_REQ; r++) begin
            req_addr_s[r] = req_line_addr_i[r*LINE_ADDR_W +: LINE_ADDR_W];
        end
    end

    // Line conflict against every busy entry; an entry being freed this
    // cycle still reads as busy, so its line cannot be re-requested yet.
    always_comb begin
        logic hit;
        hit = 1'b0;
        for (int r = 0; r < N_REQ; r++) begin
            hit = 1'b0;
            for (int e = 0; e < N_MSHR; e++) begin
                hit = hit | (busy_r[e] & (line_r[e] == req_addr_s[r]));
            end
            conflict_s[r] = req_valid_i[r] & hit;
        end
    end

    // Occupancy and lowest free id; downward scan leaves the lowest index.
    always_comb begin
        full_s     = &busy_r;
        free_cnt_s = '0;
        free_id_s  = '0;
        for (int e = N_MSHR - 1; e >= 0; e--) begin
            free_cnt_s = free_cnt_s + (N_MSHR_W + 1)'(~busy_r[e]);
            if (!busy_r[e]) begin
                free_id_s = N_MSHR_W'(e);
            end else begin
                free_id_s = free_id_s;
            end
        end
    end

    assign eligible_s = req_valid_i & ~conflict_s;

    rvh_l1d_rr_arb #(
        .N     (N_REQ),
        .PTR_W (REQ_W)
    ) u_rr_arb (
        .req   (eligible_s),
        .ptr   (rr_ptr_r),
        .grant (arb_grant_s)
    );

    // Grant qualification, winner decode and next-state masks.
    always_comb begin
        grant_en_s = ~rob_flush_i & ~full_s & (|eligible_s);
        grant_s    = grant_en_s ? arb_grant_s : '0;
        win_idx_s  = '0;
        win_addr_s = '0;
        for (int r = 0; r < N_REQ; r++) begin
            if (arb_grant_s[r]) begin
                win_idx_s  = REQ_W'(r);
                win_addr_s = req_addr_s[r];
            end else begin
                win_idx_s  = win_idx_s;
            end
        end
        if (win_idx_s == REQ_W'(N_REQ - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = win_idx_s + REQ_W'(1);
        end
        dealloc_mask_s = dealloc_valid_i ? (N_MSHR'(1) << dealloc_idx_i) : '0;
        alloc_mask_s   = grant_en_s ? (N_MSHR'(1) << free_id_s) : '0;
    end

    // Busy/line tracking, round-robin pointer and registered alloc outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r            <= '0;
            for (int e = 0; e < N_MSHR; e++) begin
                line_r[e] <= '0;
            end
            rr_ptr_r          <= '0;
            alloc_valid_r     <= 1'b0;
            alloc_id_r        <= '0;
            alloc_req_idx_r   <= '0;
            alloc_line_addr_r <= '0;
        end else begin
            // Freed id differs from the allocated one (freed ids are busy).
            busy_r        <= (busy_r & ~dealloc_mask_s) | alloc_mask_s;
            alloc_valid_r <= grant_en_s;
            if (grant_en_s) begin
                line_r[free_id_s] <= win_addr_s;
                rr_ptr_r          <= rr_next_s;
                alloc_id_r        <= free_id_s;
                alloc_req_idx_r   <= win_idx_s;
                alloc_line_addr_r <= win_addr_s;
            end else begin
                rr_ptr_r          <= rr_ptr_r;
            end
        end
    end

    assign req_ready_o       = grant_s;
    assign req_conflict_o    = conflict_s;
    assign full_o            = full_s;
    assign free_cnt_o        = free_cnt_s;
    assign alloc_valid_o     = alloc_valid_r;
    assign alloc_id_o        = alloc_id_r;
    assign alloc_req_idx_o   = alloc_req_idx_r;
    assign alloc_line_addr_o = alloc_line_addr_r;

endmodule

// File: tb/tb_rvh_l1d_mshr_alloc_arb.sv
// -----------------------------------------------------------------------------
// Testbench for rvh_l1d_mshr_alloc_arb. A driver applies directed and random
// stimulus, checks the combinational outputs against a behavioural model and
// pushes each expected allocation into a scoreboard queue; a monitor pops and
// compares whenever the registered allocation strobe appears.
// -----------------------------------------------------------------------------
module tb_rvh_l1d_mshr_alloc_arb;

    localparam int NR = 2;
    localparam int NM = 4;
    localparam int AW = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid_i;
    logic [NR*AW-1:0]  req_line_addr_i;
    logic [NR-1:0]     req_ready_o;
    logic [NR-1:0]     req_conflict_o;
    logic              alloc_valid_o;
    logic [1:0]        alloc_id_o;
    logic [0:0]        alloc_req_idx_o;
    logic [AW-1:0]     alloc_line_addr_o;
    logic              dealloc_valid_i;
    logic [1:0]        dealloc_idx_i;
    logic              rob_flush_i;
    logic              full_o;
    logic [2:0]        free_cnt_o;

    always #5 clk = ~clk;

    rvh_l1d_mshr_alloc_arb dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid_i       (req_valid_i),
        .req_line_addr_i   (req_line_addr_i),
        .req_ready_o       (req_ready_o),
        .req_conflict_o    (req_conflict_o),
        .alloc_valid_o     (alloc_valid_o),
        .alloc_id_o        (alloc_id_o),
        .alloc_req_idx_o   (alloc_req_idx_o),
        .alloc_line_addr_o (alloc_line_addr_o),
        .dealloc_valid_i   (dealloc_valid_i),
        .dealloc_idx_i     (dealloc_idx_i),
        .rob_flush_i       (rob_flush_i),
        .full_o            (full_o),
        .free_cnt_o        (free_cnt_o)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int id;
        int idx;
        int addr;
    } exp_t;
    exp_t sb_q[$];

    // Reference model: which MSHRs are held, which line each holds, and
    // which requester has priority next.
    bit  m_busy [NM];
    int  m_line [NM];
    int  m_rr;
    bit  m_valid  = 1'b0;
    bit  prev_rst = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus plus model evaluation.
    task automatic step(input logic [1:0] v, input int a0, input int a1,
                        input logic dv, input int di, input logic fl, input logic rs);
        int   addr [NR];
        bit   cf   [NR];
        bit   el   [NR];
        int   nbusy;
        int   winner;
        int   id;
        int   cand;
        logic [1:0] exp_rdy;
        logic [1:0] exp_cf;
        exp_t e;

        @(posedge clk);
        #1;
        req_valid_i     = v;
        req_line_addr_i = {AW'(a1), AW'(a0)};
        dealloc_valid_i = dv;
        dealloc_idx_i   = 2'(di);
        rob_flush_i     = fl;
        rst             = rs;
        if (prev_rst) begin
            chk("rst_alloc_valid", {31'd0, alloc_valid_o}, 32'd0);
            chk("rst_alloc_id",    {30'd0, alloc_id_o}, 32'd0);
            chk("rst_alloc_idx",   {31'd0, alloc_req_idx_o}, 32'd0);
            chk("rst_alloc_addr",  {18'd0, alloc_line_addr_o}, 32'd0);
        end

        @(negedge clk);
        addr[0] = a0 & 16'h3FFF;
        addr[1] = a1 & 16'h3FFF;
        nbusy   = 0;
        winner  = -1;
        id      = -1;
        for (int k = 0; k < NM; k++) nbusy += int'(m_busy[k]);
        for (int r = 0; r < NR; r++) begin
            cf[r] = 1'b0;
            for (int k = 0; k < NM; k++)
                if (m_busy[k] && m_line[k] == addr[r]) cf[r] = 1'b1;
            cf[r] = cf[r] && v[r];
            el[r] = v[r] && !cf[r];
        end
        if (!fl && nbusy < NM) begin
            for (int k = 0; k < NR; k++) begin
                cand = (m_rr + k) % NR;
                if (winner < 0 && el[cand]) winner = cand;
            end
        end
        for (int k = NM - 1; k >= 0; k--) if (!m_busy[k]) id = k;

        if (m_valid) begin
            exp_rdy = 2'b00;
            exp_cf  = {cf[1], cf[0]};
            if (winner >= 0) exp_rdy[winner] = 1'b1;
            chk("req_ready",    {30'd0, req_ready_o},    {30'd0, exp_rdy});
            chk("req_conflict", {30'd0, req_conflict_o}, {30'd0, exp_cf});
            chk("full",         {31'd0, full_o},         (nbusy == NM) ? 32'd1 : 32'd0);
            chk("free_cnt",     {29'd0, free_cnt_o},     32'(NM - nbusy));
        end

        if (rs) begin
            for (int k = 0; k < NM; k++) begin
                m_busy[k] = 1'b0;
                m_line[k] = 0;
            end
            m_rr    = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (dv) m_busy[di] = 1'b0;
            if (winner >= 0) begin
                e.id   = id;
                e.idx  = winner;
                e.addr = addr[winner];
                sb_q.push_back(e);
                m_busy[id] = 1'b1;
                m_line[id] = addr[winner];
                m_rr       = (winner + 1) % NR;
            end
        end
        prev_rst = rs;
    endtask

    task automatic idle();
        step(2'b00, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic reset_dut();
        step(2'b00, 0, 0, 1'b0, 0, 1'b0, 1'b1);
    endtask

    // Monitor: registered allocation strobe against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (alloc_valid_o === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("alloc_valid_unexpected", {31'd0, alloc_valid_o}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("alloc_id",   {30'd0, alloc_id_o},        32'(e.id));
                    chk("alloc_idx",  {31'd0, alloc_req_idx_o},   32'(e.idx));
                    chk("alloc_addr", {18'd0, alloc_line_addr_o}, 32'(e.addr));
                end
            end else if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("alloc_valid_missing", {31'd0, alloc_valid_o}, 32'd1);
            end
        end
    end

    initial begin
        int v, a0, a1, di, nb;
        bit dv, fl, rs;
        int cands[$];

        rst             = 1'b1;
        req_valid_i     = '0;
        req_line_addr_i = '0;
        dealloc_valid_i = 1'b0;
        dealloc_idx_i   = '0;
        rob_flush_i     = 1'b0;

        // Single request after reset: id 0, requester 0.
        reset_dut();
        step(2'b01, 14'h0A5, 0, 1'b0, 0, 1'b0, 1'b0);
        idle();

        // Alternating grants until full, then a blocked request, then a
        // same-cycle dealloc that only becomes reusable next cycle.
        reset_dut();
        step(2'b11, 14'h010, 14'h020, 1'b0, 0, 1'b0, 1'b0);
        step(2'b11, 14'h011, 14'h020, 1'b0, 0, 1'b0, 1'b0);
        step(2'b11, 14'h011, 14'h021, 1'b0, 0, 1'b0, 1'b0);
        step(2'b11, 14'h012, 14'h021, 1'b0, 0, 1'b0, 1'b0);
        step(2'b11, 14'h012, 14'h022, 1'b0, 0, 1'b0, 1'b0);
        step(2'b01, 14'h012, 0,       1'b1, 1, 1'b0, 1'b0);
        step(2'b01, 14'h012, 0,       1'b0, 0, 1'b0, 1'b0);
        idle();

        // Line conflict on entry 2, held across its dealloc, then granted.
        reset_dut();
        step(2'b01, 14'h100, 0, 1'b0, 0, 1'b0, 1'b0);
        step(2'b01, 14'h101, 0, 1'b0, 0, 1'b0, 1'b0);
        step(2'b01, 14'h123, 0, 1'b0, 0, 1'b0, 1'b0);
        step(2'b10, 0, 14'h123, 1'b0, 0, 1'b0, 1'b0);
        step(2'b10, 0, 14'h123, 1'b1, 2, 1'b0, 1'b0);
        step(2'b10, 0, 14'h123, 1'b0, 0, 1'b0, 1'b0);
        idle();

        // Same line from both requesters in one cycle.
        reset_dut();
        step(2'b11, 14'h0FF, 14'h0FF, 1'b0, 0, 1'b0, 1'b0);
        step(2'b11, 14'h0FF, 14'h0FF, 1'b0, 0, 1'b0, 1'b0);
        idle();

        // Flush blocks only the flush cycle.
        reset_dut();
        step(2'b01, 14'h055, 0, 1'b0, 0, 1'b1, 1'b0);
        step(2'b01, 14'h055, 0, 1'b0, 0, 1'b0, 1'b0);
        idle();

        // Randomized traffic over a small address pool to provoke conflicts.
        for (int i = 0; i < 3000; i++) begin
            v  = $urandom_range(0, 3);
            a0 = $urandom_range(0, 5);
            a1 = $urandom_range(0, 5);
            dv = 1'b0;
            di = 0;
            if ($urandom_range(0, 2) == 0) begin
                cands.delete();
                for (int k = 0; k < NM; k++) if (m_busy[k]) cands.push_back(k);
                nb = cands.size();
                if (nb > 0) begin
                    dv = 1'b1;
                    di = cands[$urandom_range(0, nb - 1)];
                end
            end
            fl = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 299) == 0);
            step(2'(v), a0, a1, dv, di, fl, rs);
        end

        idle();
        idle();
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
